// File: rtl/d_reg_file.sv
// d_reg_file: DEPTH x WIDTH edge-triggered register bank, one write port, two registered read ports.
// Define REGFILE_BYPASS_EN for write-first same-edge read-during-write; otherwise reads are read-first.
module d_reg_file #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid_b
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [1:0]        rd_en_p;
    logic [ADDR_W-1:0] rd_addr_p [2];
    logic [WIDTH-1:0]  rd_data_p [2];
    logic [1:0]        rd_valid_p;

    assign rd_en_p      = {rd_en_b, rd_en_a};
    assign rd_addr_p[0] = rd_addr_a;
    assign rd_addr_p[1] = rd_addr_b;
    assign rd_data_a    = rd_data_p[0];
    assign rd_data_b    = rd_data_p[1];
    assign rd_valid_a   = rd_valid_p[0];
    assign rd_valid_b   = rd_valid_p[1];

`ifdef REGFILE_BYPASS_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    logic wr_hit;

    // A write that actually lands in storage; only such writes may be forwarded.
    assign wr_hit = wr_en && ({1'b0, wr_addr} < DEPTH_L) && !(ZERO_REG && (wr_addr == '0));
`endif

    // Address decode per register; out-of-range addresses match no register and are dropped.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        if (ZERO_REG && (gi == 0)) begin : g_zero
            assign mem[gi] = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] word_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    word_reg <= wr_data;
                end
            end

            assign mem[gi] = word_reg;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [WIDTH-1:0] rd_word_next;
        logic [WIDTH-1:0] data_reg;
        logic             valid_reg;

        // Out-of-range addresses fall through the mux and return zero.
        always_comb begin
            rd_word_next = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_addr_p[gi] == ADDR_W'(i)) begin
                    rd_word_next = mem[i];
                end
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (wr_addr == rd_addr_p[gi])) begin
                rd_word_next = wr_data;
            end
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_reg  <= '0;
                valid_reg <= 1'b0;
            end else begin
                valid_reg <= rd_en_p[gi];
                if (rd_en_p[gi]) begin
                    data_reg <= rd_word_next;
                end
            end
        end

        assign rd_data_p[gi]  = data_reg;
        assign rd_valid_p[gi] = valid_reg;
    end

endmodule
